aes_encrypt_ctrl: RTL

- Iterative AES-128 encryption controller. Reuses one instance of the team's single-round datapath (SubBytes, ShiftRows, MixColumns, AddRoundKey) once per cycle across rounds 1-10.
- Generates round keys on the fly and bypasses MixColumns in round 10.
- Sits between a valid/ready block source and a valid/ready ciphertext sink.

---
 rtl/aes_encrypt_ctrl.sv | 262 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/aes_encrypt_ctrl.sv
// Iterative AES-128 encryption controller.
// One round per clock through a shared SubBytes/ShiftRows/MixColumns/AddRoundKey
// datapath, with the round key expanded on the fly from the previous one.
// Optional feature macro: AES_ENC_ABORT_EN adds an 'abort' input that cancels
// a block in RUN or DONE without an output handshake.
`timescale 1ns/1ps

module aes_encrypt_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
`ifdef AES_ENC_ABORT_EN
    input  logic         abort,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] NR_L = 4'(NR);

    // S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry i sits at bit offset 8*(255-i) = {~i, 3'b000}.
    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon_of(input logic [3:0] rnd);
        logic [7:0] rc;
        case (rnd)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = 128'h0;
        for (int k = 0; k < 16; k++) begin
            r[8*k +: 8] = sbox(s[8*k +: 8]);
        end
        return r;
    endfunction

    // Byte (row r, column c) lives at index r+4c, byte 0 in bits [127:120].
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = 128'h0;
        for (int row = 0; row < 4; row++) begin
            for (int col = 0; col < 4; col++) begin
                r[127-8*(row+4*col) -: 8] = s[127-8*(row+4*((col+row)%4)) -: 8];
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = 128'h0;
        for (int col = 0; col < 4; col++) begin
            a0 = s[127-32*col -: 8];
            a1 = s[119-32*col -: 8];
            a2 = s[111-32*col -: 8];
            a3 = s[103-32*col -: 8];
            r[127-32*col -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            r[119-32*col -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            r[111-32*col -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            r[103-32*col -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return r;
    endfunction

    function automatic logic [127:0] key_expand(input logic [127:0] rk, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, rot, sw, n0, n1, n2, n3;
        w0  = rk[127:96];
        w1  = rk[95:64];
        w2  = rk[63:32];
        w3  = rk[31:0];
        rot = {w3[23:0], w3[31:24]};
        sw  = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
        n0  = w0 ^ sw ^ {rc, 24'h000000};
        n1  = w1 ^ n0;
        n2  = w2 ^ n1;
        n3  = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    state_t         state_q, state_d;
    logic [127:0]   data_q, data_d;
    logic [127:0]   rk_q, rk_d;
    logic [3:0]     rnd_q, rnd_d;
    logic [127:0]   out_data_q, out_data_d;
    logic [127:0]   nk_s, sr_s, round_s;
    logic           abort_s;

`ifdef AES_ENC_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept in IDLE, count rounds in RUN, wait for sink in DONE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort_s) begin
                    state_d = ST_IDLE;
                end else if (rnd_q == NR_L) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (abort_s || out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_IDLE: in_ready = 1'b1;
            ST_RUN:  busy = 1'b1;
            ST_DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
                busy      = 1'b0;
            end
        endcase
    end

    assign out_data = out_data_q;

    // Round datapath: next round key, then one round; the last round skips MixColumns.
    always_comb begin
        nk_s = key_expand(rk_q, rcon_of(rnd_q));
        sr_s = shift_rows(sub_bytes(data_q));
        if (rnd_q == NR_L) begin
            round_s = sr_s ^ nk_s;
        end else begin
            round_s = mix_columns(sr_s) ^ nk_s;
        end
    end

    // Datapath next-state: load on accept, iterate in RUN, capture ciphertext on the last round.
    always_comb begin
        data_d     = data_q;
        rk_d       = rk_q;
        rnd_d      = rnd_q;
        out_data_d = out_data_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d = in_data ^ in_key;
                    rk_d   = in_key;
                    rnd_d  = 4'd1;
                end else begin
                    data_d = data_q;
                end
            end
            ST_RUN: begin
                if (abort_s) begin
                    data_d = data_q;
                end else begin
                    data_d = round_s;
                    rk_d   = nk_s;
                    if (rnd_q == NR_L) begin
                        out_data_d = round_s;
                    end else begin
                        rnd_d = rnd_q + 4'd1;
                    end
                end
            end
            ST_DONE: data_d = data_q;
            default: data_d = data_q;
        endcase
    end

    // Datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q     <= 128'h0;
            rk_q       <= 128'h0;
            rnd_q      <= 4'd0;
            out_data_q <= 128'h0;
        end else begin
            data_q     <= data_d;
            rk_q       <= rk_d;
            rnd_q      <= rnd_d;
            out_data_q <= out_data_d;
        end
    end

endmodule
